// File: rtl/fft_input_packer.sv
// Serial-to-parallel packer feeding the 512-point FFT first stage: gathers 16 complex
// samples per vector, tracks vector position in the frame and re-aligns on start-of-frame.
module fft_input_packer #(
    parameter int DATA_W  = 11,
    parameter int LANES   = 16,
    parameter int N_POINT = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic signed [DATA_W-1:0] in_i,
    input  logic signed [DATA_W-1:0] in_q,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_i [0:LANES-1],
    output logic signed [DATA_W-1:0] out_q [0:LANES-1],
    output logic                     out_sof,
    output logic                     out_eof,
    output logic                     align_err
);

    localparam int VEC_PER_FRAME = N_POINT / LANES;
    localparam int LANE_W        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VEC_W         = (VEC_PER_FRAME > 1) ? $clog2(VEC_PER_FRAME) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
    localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(VEC_PER_FRAME - 1);

    logic [LANE_W-1:0]        lane_cnt_r;
    logic [VEC_W-1:0]         vec_cnt_r;
    // The last lane is never buffered: it is taken straight from the input at emit time.
    logic signed [DATA_W-1:0] buf_i_r [0:LANES-2];
    logic signed [DATA_W-1:0] buf_q_r [0:LANES-2];

    logic                     sof_s;
    logic                     emit_s;
    logic                     err_s;
    logic [LANE_W-1:0]        wr_lane_s;
    logic [LANE_W-1:0]        lane_cnt_s;
    logic [VEC_W-1:0]         vec_cnt_s;
    logic signed [DATA_W-1:0] buf_i_s [0:LANES-2];
    logic signed [DATA_W-1:0] buf_q_s [0:LANES-2];
    logic signed [DATA_W-1:0] vec_i_s [0:LANES-1];
    logic signed [DATA_W-1:0] vec_q_s [0:LANES-1];

    // Counter next-state and event decode; start-of-frame overrides a pending emit.
    always_comb begin
        sof_s      = in_valid & in_sof;
        emit_s     = in_valid & ~in_sof & (lane_cnt_r == LANE_LAST);
        err_s      = sof_s & ((lane_cnt_r != {LANE_W{1'b0}}) | (vec_cnt_r != {VEC_W{1'b0}}));
        lane_cnt_s = lane_cnt_r;
        vec_cnt_s  = vec_cnt_r;
        if (sof_s) begin
            lane_cnt_s = LANE_W'(1);
            vec_cnt_s  = {VEC_W{1'b0}};
        end else if (emit_s) begin
            lane_cnt_s = {LANE_W{1'b0}};
            if (vec_cnt_r == VEC_LAST) begin
                vec_cnt_s = {VEC_W{1'b0}};
            end else begin
                vec_cnt_s = vec_cnt_r + VEC_W'(1);
            end
        end else if (in_valid) begin
            lane_cnt_s = lane_cnt_r + LANE_W'(1);
        end else begin
            lane_cnt_s = lane_cnt_r;
        end
    end

    // Lane buffer write and the assembled output vector.
    always_comb begin
        wr_lane_s = in_sof ? {LANE_W{1'b0}} : lane_cnt_r;
        for (int k = 0; k < LANES - 1; k++) begin
            buf_i_s[k] = buf_i_r[k];
            buf_q_s[k] = buf_q_r[k];
            if (in_valid && (wr_lane_s == LANE_W'(k))) begin
                buf_i_s[k] = in_i;
                buf_q_s[k] = in_q;
            end else begin
                buf_i_s[k] = buf_i_r[k];
                buf_q_s[k] = buf_q_r[k];
            end
        end
        for (int k = 0; k < LANES; k++) begin
            vec_i_s[k] = out_i[k];
            vec_q_s[k] = out_q[k];
        end
        if (emit_s) begin
            for (int k = 0; k < LANES - 1; k++) begin
                vec_i_s[k] = buf_i_r[k];
                vec_q_s[k] = buf_q_r[k];
            end
            vec_i_s[LANES-1] = in_i;
            vec_q_s[LANES-1] = in_q;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                vec_i_s[k] = out_i[k];
                vec_q_s[k] = out_q[k];
            end
        end
    end

    // Position counters and lane buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt_r <= {LANE_W{1'b0}};
            vec_cnt_r  <= {VEC_W{1'b0}};
            for (int k = 0; k < LANES - 1; k++) begin
                buf_i_r[k] <= {DATA_W{1'b0}};
                buf_q_r[k] <= {DATA_W{1'b0}};
            end
        end else begin
            lane_cnt_r <= lane_cnt_s;
            vec_cnt_r  <= vec_cnt_s;
            for (int k = 0; k < LANES - 1; k++) begin
                buf_i_r[k] <= buf_i_s[k];
                buf_q_r[k] <= buf_q_s[k];
            end
        end
    end

    // Registered vector, strobe and frame flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            align_err <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                out_i[k] <= {DATA_W{1'b0}};
                out_q[k] <= {DATA_W{1'b0}};
            end
        end else begin
            out_valid <= emit_s;
            out_sof   <= emit_s & (vec_cnt_r == {VEC_W{1'b0}});
            out_eof   <= emit_s & (vec_cnt_r == VEC_LAST);
            align_err <= err_s;
            for (int k = 0; k < LANES; k++) begin
                out_i[k] <= vec_i_s[k];
                out_q[k] <= vec_q_s[k];
            end
        end
    end

endmodule

// File: tb/tb_fft_input_packer.sv
// Randomised and directed bench for fft_input_packer, checked every cycle against a
// queue-based frame model.
module tb_fft_input_packer;

    localparam int DATA_W = 11;
    localparam int LANES  = 16;
    localparam int NVEC   = 32;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_sof;
    logic signed [DATA_W-1:0] in_i;
    logic signed [DATA_W-1:0] in_q;
    logic out_valid;
    logic signed [DATA_W-1:0] out_i [0:LANES-1];
    logic signed [DATA_W-1:0] out_q [0:LANES-1];
    logic out_sof;
    logic out_eof;
    logic align_err;

    always #5 clk = ~clk;

    fft_input_packer #(.DATA_W(DATA_W), .LANES(LANES), .N_POINT(512)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_i(in_i), .in_q(in_q), .out_valid(out_valid), .out_i(out_i), .out_q(out_q),
        .out_sof(out_sof), .out_eof(out_eof), .align_err(align_err)
    );

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    // model: samples of the vector being gathered plus the vector index in the frame
    logic signed [DATA_W-1:0] pq_i[$];
    logic signed [DATA_W-1:0] pq_q[$];
    int vec_idx;
    logic exp_valid, exp_sof, exp_eof, exp_err;
    logic nxt_valid, nxt_sof, nxt_eof, nxt_err;
    logic signed [DATA_W-1:0] exp_i [0:LANES-1];
    logic signed [DATA_W-1:0] exp_q [0:LANES-1];
    logic signed [DATA_W-1:0] nxt_i [0:LANES-1];
    logic signed [DATA_W-1:0] nxt_q [0:LANES-1];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pq_i.delete();
        pq_q.delete();
        vec_idx = 0;
        exp_valid = 1'b0; exp_sof = 1'b0; exp_eof = 1'b0; exp_err = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            exp_i[k] = '0;
            exp_q[k] = '0;
        end
    endtask

    task automatic predict(input logic v, input logic s, input logic signed [DATA_W-1:0] di,
                           input logic signed [DATA_W-1:0] dq);
        nxt_valid = 1'b0; nxt_sof = 1'b0; nxt_eof = 1'b0; nxt_err = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            nxt_i[k] = exp_i[k];
            nxt_q[k] = exp_q[k];
        end
        if (v) begin
            if (s) begin
                nxt_err = (pq_i.size() != 0) || (vec_idx != 0);
                pq_i.delete();
                pq_q.delete();
                vec_idx = 0;
            end
            pq_i.push_back(di);
            pq_q.push_back(dq);
            if (pq_i.size() == LANES) begin
                nxt_valid = 1'b1;
                nxt_sof = (vec_idx == 0);
                nxt_eof = (vec_idx == NVEC - 1);
                for (int k = 0; k < LANES; k++) begin
                    nxt_i[k] = pq_i[k];
                    nxt_q[k] = pq_q[k];
                end
                vec_idx = (vec_idx + 1) % NVEC;
                pq_i.delete();
                pq_q.delete();
            end
        end
    endtask

    task automatic step(input logic v, input logic s, input int di, input int dq);
        logic signed [DATA_W-1:0] ti;
        logic signed [DATA_W-1:0] tq;
        ti = DATA_W'(di);
        tq = DATA_W'(dq);
        in_valid = v;
        in_sof = s;
        in_i = ti;
        in_q = tq;
        predict(v, s, ti, tq);
        @(posedge clk);
        exp_valid = nxt_valid; exp_sof = nxt_sof; exp_eof = nxt_eof; exp_err = nxt_err;
        for (int k = 0; k < LANES; k++) begin
            exp_i[k] = nxt_i[k];
            exp_q[k] = nxt_q[k];
        end
        #1;
    endtask

    // Every-cycle comparison of the DUT against the model, mid-cycle.
    always @(negedge clk) begin
        if (check_en) begin
            int bad;
            chk("out_valid", out_valid, exp_valid);
            chk("out_sof", out_sof, exp_sof);
            chk("out_eof", out_eof, exp_eof);
            chk("align_err", align_err, exp_err);
            bad = -1;
            for (int k = LANES - 1; k >= 0; k--) begin
                if (out_i[k] !== exp_i[k] || out_q[k] !== exp_q[k]) bad = k;
            end
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL vector lane %0d: got i=%0d q=%0d expected i=%0d q=%0d at %0t",
                         bad, out_i[bad], out_q[bad], exp_i[bad], exp_q[bad], $time);
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_sof = 1'b0; in_i = '0; in_q = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_lane0", out_i[0], 0);
        rst = 1'b0;
        check_en = 1'b1;

        // 1: continuous ramp frame
        for (int n = 0; n < 512; n++) begin
            step(1'b1, n == 0, n, -n);
            if (n == 15) begin
                chk("t1_v0_lane5_i", out_i[5], 5);
                chk("t1_v0_lane5_q", out_q[5], -5);
                chk("t1_v0_sof", out_sof, 1);
            end
            if (n == 511) begin
                chk("t1_v31_lane15_i", out_i[15], 511);
                chk("t1_v31_eof", out_eof, 1);
            end
        end
        step(1'b0, 1'b0, 0, 0);

        // 2: same frame with 3-cycle gaps after every 5th sample
        for (int n = 0; n < 512; n++) begin
            step(1'b1, n == 0, n, -n);
            if (n == 31) chk("t2_v1_lane0_i", out_i[0], 16);
            if (n % 5 == 4) begin
                repeat (3) step(1'b0, 1'b0, 0, 0);
                if (n == 34) chk("t2_hold_lane15_q", out_q[15], -31);
            end
        end

        // 3: re-alignment at lane 7
        for (int n = 0; n < 7; n++) step(1'b1, 1'b0, 300 + n, n);
        step(1'b1, 1'b1, 700, -700);
        chk("t3_align_err", align_err, 1);
        for (int n = 1; n < 16; n++) step(1'b1, 1'b0, 700 + n, -700 - n);
        chk("t3_lane0_i", out_i[0], 700);
        chk("t3_sof", out_sof, 1);

        // 4: full-scale boundary values
        for (int n = 0; n < 16; n++) begin
            if (n % 2 == 0) step(1'b1, 1'b0, -1024, 1023);
            else            step(1'b1, 1'b0, 1023, -1024);
        end
        chk("t4_lane0_i", out_i[0], -1024);
        chk("t4_lane0_q", out_q[0], 1023);
        chk("t4_lane15_i", out_i[15], 1023);
        chk("t4_lane15_q", out_q[15], -1024);

        // 5: asynchronous reset mid-frame
        for (int n = 0; n < 200; n++) step(1'b1, n == 0, n, -n);
        chk("t5_pre_lane0", out_i[0], 176);
        rst = 1'b1;
        model_reset();
        #1;
        chk("t5_async_lane0", out_i[0], 0);
        chk("t5_async_q15", out_q[15], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 16; n++) step(1'b1, 1'b0, 50 + n, n);
        chk("t5_sof", out_sof, 1);
        chk("t5_lane3_i", out_i[3], 53);

        // random traffic with occasional start-of-frame markers
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0,
                 int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024);
        end
        step(1'b0, 1'b0, 0, 0);
        @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_input_packer.md
Name: fft_input_packer

Overview:
Serial-to-parallel front end for the 512-point FFT datapath. Accepts one complex 11-bit sample per clock from the sample source and assembles 16 consecutive samples into a 16-lane vector. Each vector is emitted with a single-cycle valid pulse that drives the first-stage butterfly module's `din_valid`/`din_i`/`din_q` inputs directly. Tracks vector position inside the FFT frame, supports frame re-alignment on a start-of-frame marker and flags misalignment.

Parameters:
- DATA_W, 11, bit width of each signed I/Q sample.
- LANES, 16, samples per output vector.
- N_POINT, 512, FFT frame length in samples. Must be a multiple of LANES; VEC_PER_FRAME = N_POINT/LANES = 32.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input sample qualifier. No backpressure; gaps are allowed.
- in_sof  input  1  marks the current sample as sample 0 of a frame. Ignored when in_valid=0.
- in_i  input  DATA_W signed  input real sample.
- in_q  input  DATA_W signed  input imaginary sample.
- out_valid  output  1  one-cycle pulse per completed vector.
- out_i  output  [0:LANES-1] x DATA_W signed  vector real parts; lane k holds the k-th accepted sample.
- out_q  output  [0:LANES-1] x DATA_W signed  vector imaginary parts.
- out_sof  output  1  qualified by out_valid; vector index is 0 of the frame.
- out_eof  output  1  qualified by out_valid; vector index is VEC_PER_FRAME-1.
- align_err  output  1  one-cycle pulse when in_sof arrives while a frame is in progress.

Behaviour:
- **Reset (async, rst=1):**
  - lane_cnt=0, vec_cnt=0, lane buffer all 0.
  - out_valid=0, out_sof=0, out_eof=0, align_err=0, out_i/out_q all 0.
  - Reset takes effect mid-vector or mid-frame; the partial vector is discarded.
  - After reset, packing starts at lane 0, vector 0, without needing in_sof.
- **Accept:** on each edge with in_valid=1:
  - Sample is written to buffer[lane_cnt].
  - lane_cnt increments and wraps LANES-1 -> 0.
  - in_valid=0 holds all counters and the buffer.
- **Emit:** on the edge where in_valid=1 and lane_cnt=LANES-1:
  - out_i/out_q load buffer lanes 0..LANES-2 plus the current sample in lane LANES-1, in the same edge.
  - out_valid=1 for exactly the following cycle.
  - Latency: last sample accepted at edge k -> out_valid high between edges k and k+1.
- **Output hold:** out_i/out_q keep the last vector while out_valid=0.
- **Frame flags:**
  - out_sof = (vec_cnt==0) and out_eof = (vec_cnt==VEC_PER_FRAME-1), both sampled at the emit edge.
  - vec_cnt increments on each emit and wraps to 0 after VEC_PER_FRAME-1.
  - out_sof/out_eof are 0 whenever out_valid=0.
- **Re-alignment:** in_valid=1 and in_sof=1:
  - The sample is written to lane 0 and lane_cnt becomes 1; vec_cnt becomes 0.
  - Any partial vector is dropped and no out_valid is generated for it.
  - If (lane_cnt!=0 or vec_cnt!=0) before this edge, align_err pulses for one cycle.
  - in_sof at a natural frame boundary (lane_cnt=0, vec_cnt=0) gives no error.
  - in_sof on what would be lane LANES-1 is still treated as re-alignment; no emit occurs that edge.
- **Back-to-back vectors:** a continuous in_valid stream gives out_valid on every 16th cycle with no gaps. An N_POINT-sample frame yields exactly 32 pulses, the first with out_sof and the last with out_eof.
- **Pass-through:** no arithmetic; samples pass bit-exact with no saturation or rounding.

Test Plan:
1. Reset, then 512 continuous samples with in_i=n, in_q=-n (n=0..511) and in_sof on n=0 -> 32 out_valid pulses 16 cycles apart. Vector m has out_i[k]=16m+k and out_q[k]=-(16m+k). out_sof only on m=0, out_eof only on m=31, align_err never asserts.
2. Same stream with in_valid deasserted for 3 cycles after every 5th sample -> identical vector contents. Each out_valid follows its 16th accepted sample by exactly one cycle, and outputs hold between pulses.
3. Assert in_sof on sample 7 of a frame (lane_cnt=7) -> align_err pulses once and the partial vector is not emitted. The next out_valid carries that sample in lane 0 with out_sof=1.
4. Boundary values: in_i=-1024/+1023 and in_q=+1023/-1024 alternating -> lanes reproduce the values bit-exact with sign intact.
5. Assert rst for 1 cycle after 200 samples of a frame -> all outputs 0 immediately (asynchronous). Next 16 samples produce a vector with out_sof=1 and no align_err.
